// File: rtl/integration_pkg.sv
// Shared AHB encodings and the SRAM responder state type.
// Latency: none, declarations only.
// Backpressure: not applicable.
package integration_pkg;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } ahb_slv_state_t;

endpackage

// File: rtl/ahb_sram_slave_wstrb_gen.sv
// Byte-strobe generator: maps transfer size and low address bits to byte lanes.
// Latency: combinational.
// Backpressure: not applicable.
module ahb_slv_wstrb_gen (
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misaligned
);

  // Little-endian lanes; misaligned halves/words are aligned down and flagged.
  always_comb begin
    strb       = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      3'b000: strb = 4'b0001 << addr_lo;
      3'b001: begin
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      3'b010: begin
        strb       = 4'b1111;
        misaligned = |addr_lo;
      end
      default: strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder with configurable wait states; AHB_SLV_ERR_RESP_EN enables ERROR responses.
// Latency: completes WAIT_STATES+1 cycles after the address phase; errors take two cycles.
// Backpressure: drives hreadyout low during wait states and the first ERROR cycle.
module ahb_sram_slave #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic        hready_in,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);
  import integration_pkg::*;

  localparam int AW       = $clog2(MEM_WORDS);
  localparam int CW       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  ahb_slv_state_t state;
  logic [CW-1:0]  cnt;

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [3:0]    strb;
  logic          misaligned;
  logic          take;
  logic          take_legal;

  logic          dp_vld;
  logic          dp_write;
  logic [AW-1:0] dp_idx;
  logic [3:0]    dp_strb;

  logic [31:0]   mem [MEM_WORDS];
  logic          wr_commit;
  logic          rd_load;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_merged;

  // Out-of-range offsets simply wrap into the array when errors are disabled.
  assign offset   = haddr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];

  ahb_slv_wstrb_gen u_wstrb (
    .hsize      (hsize),
    .addr_lo    (haddr[1:0]),
    .strb       (strb),
    .misaligned (misaligned)
  );

  // Only states with hreadyout=1 (IDLE/ERR2) may accept a new address phase.
  assign take = hsel & hready_in & htrans[1] & hreadyout;

`ifdef AHB_SLV_ERR_RESP_EN
  hresp_t resp_q;
  logic   illegal;
  assign illegal    = (hsize > 3'b010) | misaligned | (|offset[31:AW+2]);
  assign take_legal = take & ~illegal;
  assign hresp      = resp_q;
`else
  assign take_legal = take;
  assign hresp      = HRESP_OKAY;
`endif

  // Response FSM: wait-state countdown and the two-cycle ERROR sequence.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hreadyout <= 1'b1;
`ifdef AHB_SLV_ERR_RESP_EN
      resp_q    <= HRESP_OKAY;
`endif
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == CW'(1)) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
          end
          cnt <= cnt - CW'(1);
        end
`ifdef AHB_SLV_ERR_RESP_EN
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          resp_q    <= HRESP_ERROR;
        end
`endif
        default: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
`ifdef AHB_SLV_ERR_RESP_EN
          resp_q    <= HRESP_OKAY;
`endif
          if (take) begin
`ifdef AHB_SLV_ERR_RESP_EN
            if (illegal) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              resp_q    <= HRESP_ERROR;
            end else
`endif
            if (HAS_WAIT) begin
              state     <= ST_WAIT;
              cnt       <= CW'(WAIT_STATES);
              hreadyout <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Data-phase registers refresh whenever the previous data phase is ending.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= '0;
    end else if (hreadyout) begin
      dp_vld   <= take_legal;
      dp_write <= hwrite;
      dp_idx   <= word_idx;
      dp_strb  <= strb;
    end
  end

  // Write commits at the edge closing a legal write's completing cycle.
  assign wr_commit = dp_vld & dp_write & hreadyout;

  // Zero-wait reads load at the accept edge; otherwise at the last wait edge.
  assign rd_load = HAS_WAIT ? ((state == ST_WAIT) && (cnt == CW'(1)) && !dp_write)
                            : (take_legal && !hwrite);
  assign rd_idx  = HAS_WAIT ? dp_idx : word_idx;

  // Forward lanes from a write committing to the same word on the same edge.
  always_comb begin
    rd_merged = mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (wr_commit && (dp_idx == rd_idx) && dp_strb[i]) begin
        rd_merged[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  // SRAM array write port; contents survive reset.
  always_ff @(posedge hclk) begin
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_strb[i]) begin
          mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // Read data register holds its value between reads.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      hrdata <= '0;
    end else if (rd_load) begin
      hrdata <= rd_merged;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance against a word-array model.
// Latency: not applicable.
// Backpressure: the bus HREADY follows the selected slave's hreadyout.
module tb_ahb_sram_slave;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        hclk   = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel0  = 1'b0;
  logic        hsel3  = 1'b0;
  logic [31:0] haddr  = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize  = '0;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;
  bit          tgt      = 1'b0;
  bit          gate_low = 1'b0;

  logic        ho0, ho3;
  logic [1:0]  hr0, hr3;
  logic [31:0] rd0, rd3;
  logic        cur_ho, hready_bus;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rd;

  logic [31:0] mdl [2][MW];
  int n_cmp  = 0;
  int n_fail = 0;

  assign cur_ho     = tgt ? ho3 : ho0;
  assign cur_resp   = tgt ? hr3 : hr0;
  assign cur_rd     = tgt ? rd3 : rd0;
  assign hready_bus = gate_low ? 1'b0 : cur_ho;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .hready_in(hready_bus),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hreadyout(ho0), .hresp(hr0), .hrdata(rd0)
  );

  ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .hready_in(hready_bus),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hreadyout(ho3), .hresp(hr3), .hrdata(rd3)
  );

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % MW);
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLV_ERR_RESP_EN
    logic [31:0] off;
    off = a - BASE;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && a[0]) return 1'b1;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    if (off >= MW * 4) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Transfer of 2^size bytes (word when larger), starting address rounded down to its size.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [2:0] s, input logic [31:0] wd);
    int n, lo;
    logic [31:0] r;
    n  = (s >= 3'd2) ? 4 : (1 << s);
    lo = (int'(a[1:0]) / n) * n;
    r  = old;
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + n) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic drive_addr(input bit t, input bit wr, input logic [31:0] a, input logic [2:0] s);
    tgt    = t;
    hsel0  = !t;
    hsel3  = t;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = s;
    hburst = 3'b000;
  endtask

  task automatic drive_idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
  endtask

  // One non-pipelined transfer, checked against the model; starts and ends at a negedge.
  task automatic do_xfer(input bit t, input bit wr, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd, input string nm, output logic [31:0] rdata);
    bit err;
    int ws, waits;
    logic [31:0] exp;
    err = is_err(a, s);
    ws  = t ? 3 : 0;
    exp = mdl[t][widx(a)];
    drive_addr(t, wr, a, s);
    @(negedge hclk);
    drive_idle();
    hwdata = wd;
    waits  = 0;
    if (err) begin
      n_cmp++;
      if (cur_resp !== 2'b01) begin
        n_fail++;
        $display("FAIL %s err_first_resp got=%b want=01", nm, cur_resp);
      end
    end
    while (cur_ho !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge hclk);
    end
    n_cmp++;
    if (waits != (err ? 1 : ws)) begin
      n_fail++;
      $display("FAIL %s wait_cycles got=%0d want=%0d addr=%h", nm, waits, err ? 1 : ws, a);
    end
    n_cmp++;
    if (cur_resp !== (err ? 2'b01 : 2'b00)) begin
      n_fail++;
      $display("FAIL %s resp got=%b want=%b addr=%h", nm, cur_resp, err ? 2'b01 : 2'b00, a);
    end
    rdata = cur_rd;
    if (!wr && !err) begin
      n_cmp++;
      if (cur_rd !== exp) begin
        n_fail++;
        $display("FAIL %s rdata got=%h want=%h addr=%h size=%0d", nm, cur_rd, exp, a, s);
      end
    end
    if (wr && !err) mdl[t][widx(a)] = merge(exp, a, s, wd);
  endtask

  task automatic test_reset();
    #1 hreset = 1'b0;
    #2;
    n_cmp += 6;
    if (ho0 !== 1'b1)  begin n_fail++; $display("FAIL reset_hreadyout0 got=%b want=1", ho0); end
    if (hr0 !== 2'b00) begin n_fail++; $display("FAIL reset_hresp0 got=%b want=00", hr0); end
    if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata0 got=%h want=0", rd0); end
    if (ho3 !== 1'b1)  begin n_fail++; $display("FAIL reset_hreadyout3 got=%b want=1", ho3); end
    if (hr3 !== 2'b00) begin n_fail++; $display("FAIL reset_hresp3 got=%b want=00", hr3); end
    if (rd3 !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata3 got=%h want=0", rd3); end
    @(negedge hclk);
    hreset = 1'b1;
  endtask

  task automatic test_preload();
    logic [31:0] rd;
    for (int t = 0; t < 2; t++)
      for (int w = 0; w < MW; w++)
        do_xfer(t[0], 1'b1, BASE + 32'(4 * w), 3'd2, $urandom, "preload", rd);
  endtask

  task automatic test_back_to_back(input bit t);
    int ws, waits;
    logic [31:0] a;
    ws = t ? 3 : 0;
    a  = BASE + 32'h10;
    drive_addr(t, 1'b1, a, 3'd2);
    @(negedge hclk);
    hwdata = 32'hDEAD_BEEF;
    hwrite = 1'b0;
    waits  = 0;
    while (cur_ho !== 1'b1 && waits < 40) begin waits++; @(negedge hclk); end
    n_cmp++;
    if (waits != ws) begin n_fail++; $display("FAIL b2b_wr_waits got=%0d want=%0d", waits, ws); end
    @(negedge hclk);
    drive_idle();
    waits = 0;
    while (cur_ho !== 1'b1 && waits < 40) begin waits++; @(negedge hclk); end
    n_cmp += 3;
    if (waits != ws) begin n_fail++; $display("FAIL b2b_rd_waits got=%0d want=%0d", waits, ws); end
    if (cur_resp !== 2'b00) begin n_fail++; $display("FAIL b2b_resp got=%b want=00", cur_resp); end
    if (cur_rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL b2b_rdata got=%h want=deadbeef", cur_rd);
    end
    mdl[t][widx(a)] = 32'hDEAD_BEEF;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        exp_ho;
    logic [31:0] exp_rd;
    do_xfer(1'b1, 1'b1, BASE + 32'h20, 3'd2, 32'h1234_5678, "ws_pre_a", rd);
    do_xfer(1'b1, 1'b1, BASE + 32'h24, 3'd2, 32'h9ABC_DEF0, "ws_pre_b", rd);
    do_xfer(1'b1, 1'b0, BASE + 32'h24, 3'd2, 32'h0, "ws_prev_read", rd);
    drive_addr(1'b1, 1'b0, BASE + 32'h20, 3'd2);
    @(negedge hclk);
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      exp_ho = (i == 3);
      exp_rd = (i == 3) ? 32'h1234_5678 : 32'h9ABC_DEF0;
      n_cmp += 2;
      if (cur_ho !== exp_ho) begin
        n_fail++; $display("FAIL ws_hreadyout cyc=%0d got=%b want=%b", i, cur_ho, exp_ho);
      end
      if (cur_rd !== exp_rd) begin
        n_fail++; $display("FAIL ws_hrdata cyc=%0d got=%h want=%h", i, cur_rd, exp_rd);
      end
      if (i < 3) @(negedge hclk);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd;
    do_xfer(1'b0, 1'b1, BASE + 32'h10, 3'd2, 32'h0, "bw_clear", rd);
    do_xfer(1'b0, 1'b1, BASE + 32'h13, 3'd0, 32'hA5A5_A5A5, "bw_byte", rd);
    do_xfer(1'b0, 1'b0, BASE + 32'h10, 3'd2, 32'h0, "bw_read", rd);
    n_cmp++;
    if (rd !== 32'hA500_0000) begin n_fail++; $display("FAIL bw_word got=%h want=a5000000", rd); end
  endtask

  task automatic test_gated();
    logic [31:0] rd;
    drive_addr(1'b0, 1'b1, BASE + 32'h10, 3'd2);
    htrans = 2'b01;
    @(negedge hclk);
    n_cmp += 2;
    if (cur_ho !== 1'b1)    begin n_fail++; $display("FAIL busy_hreadyout got=%b want=1", cur_ho); end
    if (cur_resp !== 2'b00) begin n_fail++; $display("FAIL busy_hresp got=%b want=00", cur_resp); end
    htrans   = 2'b10;
    gate_low = 1'b1;
    @(negedge hclk);
    gate_low = 1'b0;
    drive_idle();
    hwdata = $urandom;
    n_cmp += 2;
    if (cur_ho !== 1'b1)    begin n_fail++; $display("FAIL nrdy_hreadyout got=%b want=1", cur_ho); end
    if (cur_resp !== 2'b00) begin n_fail++; $display("FAIL nrdy_hresp got=%b want=00", cur_resp); end
    @(negedge hclk);
    do_xfer(1'b0, 1'b0, BASE + 32'h10, 3'd2, 32'h0, "gated_readback", rd);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    drive_addr(1'b1, 1'b1, BASE + 32'h30, 3'd2);
    @(negedge hclk);
    drive_idle();
    hwdata = ~mdl[1][widx(BASE + 32'h30)];
    @(negedge hclk);
    n_cmp++;
    if (ho3 !== 1'b0) begin n_fail++; $display("FAIL rmid_in_wait got=%b want=0", ho3); end
    hreset = 1'b0;
    #1;
    n_cmp += 4;
    if (ho3 !== 1'b1)  begin n_fail++; $display("FAIL rmid_hreadyout got=%b want=1", ho3); end
    if (hr3 !== 2'b00) begin n_fail++; $display("FAIL rmid_hresp got=%b want=00", hr3); end
    if (rd3 !== 32'h0) begin n_fail++; $display("FAIL rmid_hrdata3 got=%h want=0", rd3); end
    if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rmid_hrdata0 got=%h want=0", rd0); end
    @(negedge hclk);
    hreset = 1'b1;
    @(negedge hclk);
    do_xfer(1'b1, 1'b0, BASE + 32'h30, 3'd2, 32'h0, "rmid_readback", rd);
  endtask

`ifdef AHB_SLV_ERR_RESP_EN
  task automatic test_error();
    logic [31:0] rd;
    do_xfer(1'b0, 1'b1, BASE + 32'h11, 3'd1, 32'hFFFF_FFFF, "err_half_misal", rd);
    do_xfer(1'b0, 1'b0, BASE + 32'h10, 3'd2, 32'h0, "err_half_readback", rd);
    do_xfer(1'b1, 1'b1, BASE + 32'(MW * 4), 3'd2, 32'hFFFF_FFFF, "err_range", rd);
    do_xfer(1'b1, 1'b0, BASE, 3'd2, 32'h0, "err_range_readback", rd);
    do_xfer(1'b0, 1'b0, BASE + 32'h8, 3'd3, 32'h0, "err_size", rd);
  endtask
`else
  task automatic test_wrap();
    logic [31:0] rd;
    do_xfer(1'b0, 1'b1, BASE + 32'(MW * 4 + 8), 3'd2, 32'hA1B2_C3D4, "wrap_write", rd);
    do_xfer(1'b0, 1'b0, BASE + 32'h8, 3'd2, 32'h0, "wrap_read", rd);
    n_cmp++;
    if (rd !== 32'hA1B2_C3D4) begin n_fail++; $display("FAIL wrap_word got=%h want=a1b2c3d4", rd); end
    do_xfer(1'b0, 1'b1, BASE + 32'h8, 3'd0, 32'h0, "align_clear", rd);
    do_xfer(1'b0, 1'b1, BASE + 32'hB, 3'd1, 32'h5566_7788, "align_half", rd);
    do_xfer(1'b0, 1'b0, BASE + 32'h8, 3'd2, 32'h0, "align_read", rd);
    n_cmp++;
    if (rd !== 32'h5566_C300) begin n_fail++; $display("FAIL align_word got=%h want=5566c300", rd); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, a;
    logic [2:0]  s;
    bit          t, wr;
    int          n;
    for (int k = 0; k < 120; k++) begin
      t  = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      s  = 3'($urandom_range(0, 3));
      a  = BASE + 32'($urandom_range(0, MW * 4 - 1));
      n  = (s >= 3'd2) ? 4 : (1 << s);
      if ($urandom_range(0, 3) != 0) a = a - 32'(int'(a[1:0]) % n);
      if ($urandom_range(0, 9) == 0) a = a + 32'(MW * 4);
      do_xfer(t, wr, a, s, $urandom, "random", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_wait_states();
    test_byte_write();
    test_gated();
    test_reset_mid();
`ifdef AHB_SLV_ERR_RESP_EN
    test_error();
`else
    test_wrap();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
